// File: rtl/split_fifo_deep_if.sv
// Handshake/data bundle for split_fifo_deep: upstream (data_in/valid0/ready0)
// and downstream (data_out/valid1/ready1) sides.
interface split_fifo_deep_if #(
  parameter int DATA_WIDTH = 17
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid0;
  logic                  ready0;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid1;
  logic                  ready1;

  modport master (
    output data_in, valid0, ready1,
    input  ready0, data_out, valid1
  );

  modport slave (
    input  data_in, valid0, ready1,
    output ready0, data_out, valid1
  );
endinterface

// File: rtl/split_fifo_deep.sv
// Splittable FIFO with zero-latency bypass when empty, or a plain enabled pipeline register.
// Optional occupancy port enabled by defining SPLIT_FIFO_DEEP_COUNT_EN.
module split_fifo_deep #(
  parameter int DATA_WIDTH = 17,
  parameter int DEPTH      = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_en,
  input  logic fifo_en,
  input  logic start_fifo,
  input  logic end_fifo,
  split_fifo_deep_if.slave bus
`ifdef SPLIT_FIFO_DEEP_COUNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] count
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam logic [CW-1:0] OCC_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] OCC_FULL = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]         rd_ptr_r;
  logic [AW-1:0]         wr_ptr_r;
  logic [CW-1:0]         occ_r;

  logic ready_in_s;
  logic valid_in_s;
  logic empty_s;
  logic full_s;
  logic push_s;
  logic pop_s;
  logic bypass_s;

  // start_fifo/end_fifo cut the combinational ready/valid paths through the FIFO
  assign ready_in_s = bus.ready1 & ~start_fifo;
  assign valid_in_s = bus.valid0 & ~end_fifo;
  assign empty_s    = (occ_r == {CW{1'b0}});
  assign full_s     = (occ_r == OCC_FULL);

  assign bus.ready0   = fifo_en ? (~full_s | ready_in_s) : clk_en;
  assign bus.valid1   = fifo_en ? (~empty_s | valid_in_s) : clk_en;
  assign bus.data_out = (fifo_en & empty_s) ? bus.data_in : mem_r[rd_ptr_r];

  assign push_s   = clk_en & fifo_en & bus.valid0 & bus.ready0;
  assign pop_s    = clk_en & fifo_en & bus.valid1 & bus.ready1;
  assign bypass_s = empty_s & push_s & pop_s;

  // Storage: FIFO writes, or pipeline-register capture into the read slot when fifo_en=0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (clk_en) begin
      if (!fifo_en) begin
        mem_r[rd_ptr_r] <= bus.data_in;
      end else if (push_s && !bypass_s) begin
        mem_r[wr_ptr_r] <= bus.data_in;
      end
    end
  end

  // Pointers and occupancy; pointer wrap relies on DEPTH being a power of two
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      occ_r    <= {CW{1'b0}};
    end else if (clk_en && fifo_en) begin
      if (push_s && !bypass_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s && !empty_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (push_s && !pop_s) begin
        occ_r <= occ_r + OCC_ONE;
      end else if (pop_s && !push_s && !empty_s) begin
        occ_r <= occ_r - OCC_ONE;
      end
    end
  end

`ifdef SPLIT_FIFO_DEEP_COUNT_EN
  assign count = occ_r;
`endif

endmodule
